// File: rtl/multichannel_input_conditioner.sv
// rtl/multichannel_input_conditioner.sv - per-channel synchronizer, debounce filter and edge detector
// Each async input is synchronized, accepted only after F+1 stable cycles, then pulsed on change.
module multichannel_input_conditioner #(
  parameter int WIDTH         = 4,
  parameter int NUM_OF_STAGES = 2,
  parameter int FILTER_CYCLES = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  input  logic [WIDTH-1:0] pulse_mask,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             any_event
);

  localparam int CW = (FILTER_CYCLES < 1) ? 1 : $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES);

  generate
    if (NUM_OF_STAGES < 2) begin : g_bad_stages
      $error("NUM_OF_STAGES must be at least 2");
    end
  endgenerate

  logic [WIDTH-1:0] sync_stage [NUM_OF_STAGES];
  logic [WIDTH-1:0] sync_q;
  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] accept;

  // Plain flop chain: nothing may sit between stages or metastability protection is lost.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_OF_STAGES; i++) sync_stage[i] <= '0;
    end else begin
      sync_stage[0] <= async_in;
      for (int i = 1; i < NUM_OF_STAGES; i++) sync_stage[i] <= sync_stage[i-1];
    end
  end

  assign sync_q = sync_stage[NUM_OF_STAGES-1];

  always_comb begin
    accept = '0;
    for (int c = 0; c < WIDTH; c++) begin
      accept[c] = (sync_q[c] != level_out[c]) && (cnt[c] == CNT_MAX);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < WIDTH; c++) cnt[c] <= '0;
      level_out  <= '0;
      rise_pulse <= '0;
      fall_pulse <= '0;
    end else begin
      for (int c = 0; c < WIDTH; c++) begin
        if (sync_q[c] == level_out[c]) begin
          cnt[c] <= '0;
        end else if (cnt[c] == CNT_MAX) begin
          level_out[c] <= sync_q[c];
          cnt[c]       <= '0;
        end else begin
          cnt[c] <= cnt[c] + 1'b1;
        end
      end
      // Pulses land with the first cycle of the new level; mask only matters at acceptance.
      rise_pulse <= accept & sync_q & ~pulse_mask;
      fall_pulse <= accept & ~sync_q & ~pulse_mask;
    end
  end

  assign any_event = |(rise_pulse | fall_pulse);

endmodule

// File: tb/tb_multichannel_input_conditioner.sv
// tb/tb_multichannel_input_conditioner.sv - directed self-checking bench for multichannel_input_conditioner
// Covers the default F=3 build and a second F=0 build driven separately.
module tb_multichannel_input_conditioner;

  logic       clock;
  logic       reset;
  logic [3:0] async_in, pulse_mask;
  logic [3:0] level_out, rise_pulse, fall_pulse;
  logic       any_event;
  logic [3:0] async_f0, mask_f0;
  logic [3:0] level_f0, rise_f0, fall_f0;
  logic       any_f0;

  int checks = 0;
  int errors = 0;

  multichannel_input_conditioner #(.WIDTH(4), .NUM_OF_STAGES(2), .FILTER_CYCLES(3)) dut (
    .clock(clock), .reset(reset), .async_in(async_in), .pulse_mask(pulse_mask),
    .level_out(level_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .any_event(any_event)
  );

  multichannel_input_conditioner #(.WIDTH(4), .NUM_OF_STAGES(2), .FILTER_CYCLES(0)) dut_f0 (
    .clock(clock), .reset(reset), .async_in(async_f0), .pulse_mask(mask_f0),
    .level_out(level_f0), .rise_pulse(rise_f0), .fall_pulse(fall_f0), .any_event(any_f0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] lvl, input logic [3:0] r,
                           input logic [3:0] f, input logic ev);
    check({tag, "_level"}, {4'h0, level_out}, {4'h0, lvl});
    check({tag, "_rise"},  {4'h0, rise_pulse}, {4'h0, r});
    check({tag, "_fall"},  {4'h0, fall_pulse}, {4'h0, f});
    check({tag, "_any"},   {7'h0, any_event}, {7'h0, ev});
  endtask

  // Hold async_in for six edges and verify acceptance lands exactly at E5.
  task automatic transition(input string tag, input logic [3:0] in, input logic [3:0] old_lvl,
                            input logic [3:0] r, input logic [3:0] f);
    async_in = in;
    for (int e = 0; e < 5; e++) begin
      step();
      check({tag, "_hold"}, {4'h0, level_out}, {4'h0, old_lvl});
    end
    step();
    check_all({tag, "_e5"}, in, r, f, |(r | f));
    step();
    check_all({tag, "_e6"}, in, 4'b0000, 4'b0000, 1'b0);
  endtask

  initial begin
    reset = 1'b1; async_in = 4'b0000; pulse_mask = 4'b0000;
    async_f0 = 4'b0000; mask_f0 = 4'b0000;
    #1;
    check_all("reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    step(); step();
    reset = 1'b0;

    for (int k = 0; k < 20; k++) begin
      step();
      check_all("idle", 4'b0000, 4'b0000, 4'b0000, 1'b0);
      check("idle_f0_level", {4'h0, level_f0}, 8'h00);
    end

    // F=0 build: single-cycle input blip is accepted, then the return is accepted too.
    async_f0 = 4'b0001;
    step();
    async_f0 = 4'b0000;
    check("f0_e0_level", {4'h0, level_f0}, 8'h00);
    step();
    check("f0_e1_level", {4'h0, level_f0}, 8'h00);
    step();
    check("f0_e2_level", {4'h0, level_f0}, 8'h01);
    check("f0_e2_rise",  {4'h0, rise_f0},  8'h01);
    check("f0_e2_any",   {7'h0, any_f0},   8'h01);
    step();
    check("f0_e3_level", {4'h0, level_f0}, 8'h00);
    check("f0_e3_rise",  {4'h0, rise_f0},  8'h00);
    check("f0_e3_fall",  {4'h0, fall_f0},  8'h01);
    step();
    check("f0_e4_any",   {7'h0, any_f0},   8'h00);

    transition("ch0_rise", 4'b0001, 4'b0000, 4'b0001, 4'b0000);

    // ch1 glitch: three cycles high is one short of acceptance.
    async_in = 4'b0011;
    step(); step(); step();
    async_in = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      step();
      check_all("glitch", 4'b0001, 4'b0000, 4'b0000, 1'b0);
    end
    transition("ch1_rise", 4'b0011, 4'b0001, 4'b0010, 4'b0000);

    transition("ch2_rise", 4'b0111, 4'b0011, 4'b0100, 4'b0000);
    pulse_mask = 4'b0100;
    async_in = 4'b0011;
    for (int e = 0; e < 5; e++) begin
      step();
      check("mask_hold_any", {7'h0, any_event}, 8'h00);
    end
    step();
    check_all("mask_e5", 4'b0011, 4'b0000, 4'b0000, 1'b0);
    pulse_mask = 4'b0000;
    step(); step();
    check_all("mask_noreplay", 4'b0011, 4'b0000, 4'b0000, 1'b0);
    transition("ch2_rise2", 4'b0111, 4'b0011, 4'b0100, 4'b0000);
    transition("ch2_fall", 4'b0011, 4'b0111, 4'b0000, 4'b0100);

    transition("ch0_fall", 4'b0010, 4'b0011, 4'b0000, 4'b0001);
    transition("ch03_rise", 4'b1011, 4'b0010, 4'b1001, 4'b0000);
    transition("ch1_fall", 4'b1001, 4'b1011, 4'b0000, 4'b0010);

    // Reset in the middle of ch1's filter count, between clock edges.
    async_in = 4'b1011;
    step(); step(); step(); step();
    check("pre_reset_level", {4'h0, level_out}, 8'h09);
    #2 reset = 1'b1;
    #1;
    check_all("async_reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    #2 reset = 1'b0;
    for (int e = 0; e < 5; e++) begin
      step();
      check_all("post_reset_hold", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end
    step();
    check_all("post_reset_e5", 4'b1011, 4'b1011, 4'b0000, 1'b1);
    step();
    check_all("post_reset_e6", 4'b1011, 4'b0000, 4'b0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
